// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_driver
// Description : Drives a bank of JK flip-flops toward a latched target word.
//               It pulses J/K for one cycle, waits for the bank to settle,
//               compares, and retries a bounded number of times.
//               Optional macro JK_BANK_TOGGLE_EN: differing bits are driven as
//               toggle (J=K=1) instead of set/reset.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_driver #(
  parameter int W         = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enabled,
  input  logic         start,
  input  logic [W-1:0] target,
  input  logic [W-1:0] q_fb,
  output logic [W-1:0] J,
  output logic [W-1:0] K,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  localparam logic [2:0] C_MAX_RETRY = 3'(MAX_RETRY);

  state_t       state_q, state_d;
  logic [W-1:0] target_q, target_d;
  logic [W-1:0] j_q, j_d;
  logic [W-1:0] k_q, k_d;
  logic [2:0]   retry_q, retry_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic [W-1:0] w_src_t;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_exc_j;
  logic [W-1:0] w_exc_k;

  // In IDLE the excitation is formed from the incoming word being accepted.
  assign w_src_t = (state_q == S_IDLE) ? target : target_q;
  assign w_diff  = w_src_t ^ q_fb;

`ifdef JK_BANK_TOGGLE_EN
  assign w_exc_j = w_diff;
  assign w_exc_k = w_diff;
`else
  assign w_exc_j = w_diff & w_src_t;
  assign w_exc_k = w_diff & ~w_src_t;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    retry_d  = retry_q;
    j_d      = '0;
    k_d      = '0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;

    if (!enabled) begin
      // Frozen in APPLY: keep the pending excitation tracking q_fb so the
      // value presented on re-enable reflects the bank as it is then.
      if (state_q == S_APPLY) begin
        j_d = w_exc_j;
        k_d = w_exc_k;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            target_d = target;
            j_d      = w_exc_j;
            k_d      = w_exc_k;
            retry_d  = 3'd0;
            err_d    = 1'b0;
            busy_d   = 1'b1;
            state_d  = S_APPLY;
          end
        end
        S_APPLY: begin
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (q_fb == target_q) begin
            done_d  = 1'b1;
            err_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (retry_q < C_MAX_RETRY) begin
            retry_d = retry_q + 3'd1;
            j_d     = w_exc_j;
            k_d     = w_exc_k;
            state_d = S_APPLY;
          end else begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      j_q      <= '0;
      k_q      <= '0;
      retry_q  <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      j_q      <= j_d;
      k_q      <= k_d;
      retry_q  <= retry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Dropping enabled silences the bank at once, not one edge later.
  assign J    = j_q & {W{enabled}};
  assign K    = k_q & {W{enabled}};
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: doc/jk_bank_driver.md
# jk_bank_driver

Command-side controller for a bank of W JK flip-flops built from the lab's JK cell. It accepts a target word and computes the per-bit JK excitation (hold / set / reset, or toggle) from the bank's fed-back Q. It drives J/K for exactly one clock, waits for the bank to settle, then checks the fed-back Q against the target. On mismatch it retries a bounded number of times, then reports done with an error flag. It sits between test/control logic and any FFJK-based register or counter.

## Interface
- W, default 4: width of target word and of the driven JK bank.
- MAX_RETRY, default 2: extra apply attempts after the first before err is raised (0..7).
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enabled  input  1  high: FSM advances; low: FSM frozen, J/K forced to 0.
- start  input  1  request; accepted only in IDLE with enabled=1.
- target  input  W  desired bank value, latched on acceptance.
- q_fb  input  W  Q outputs of the driven JK bank.
- J  output  W  J inputs to bank (registered).
- K  output  W  K inputs to bank (registered).
- busy  output  1  high from the edge after acceptance until completion.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; held until next accepted start.

## Operation
- Reset values: J=0, K=0, busy=0, done=0, err=0, retry counter=0, state=IDLE, latched target=0.
- States: IDLE, APPLY, SETTLE.
- Excitation per bit i (t = latched target, q = q_fb at the computing edge):
  - t=q: J=0, K=0 (hold).
  - t=1, q=0: J=1, K=0.
  - t=0, q=1: J=0, K=1.
- IDLE: J=K=0, done=0.
  - On start=1 and enabled=1: latch target; register J/K from target and q_fb; clear err and the retry counter; set busy; go to APPLY.
- APPLY: J/K are presented for this one cycle. On the next edge: J=K=0, go to SETTLE.
- SETTLE: on the next edge, compare q_fb with the latched target.
  - Match: done=1, err=0, busy=0, go to IDLE.
  - Mismatch with retry counter < MAX_RETRY: increment the counter, recompute J/K from current q_fb, go to APPLY.
  - Mismatch with counter = MAX_RETRY: done=1, err=1, busy=0, go to IDLE.
- start while busy: ignored. The latched target is unaffected by changes on the target input.
- enabled=0:
  - State, counter and latched target hold.
  - J/K are driven 0 so the bank holds.
  - A done pulse already asserted still lasts exactly one cycle.
  - On re-enable in APPLY, J/K are recomputed from the current q_fb before they are presented.
- Reset mid-operation: immediately returns all outputs and state to reset values. No done pulse.
- Target equal to the current bank value: one full APPLY/SETTLE pass with J=K=0, then done with err=0.

## Timing
- Edge numbering: start sampled high at edge 0.
- Success on first try:
  - J/K valid in the cycle after edge 0.
  - The bank updates at edge 1. J/K return to 0 after edge 1.
  - Compare at edge 2. done high in the cycle after edge 2.
  - Latency: 3 edges from start to done.
- Each retry adds 2 edges. Worst case: 3 + 2*MAX_RETRY edges.
- busy falls in the same cycle done rises.
- A new start is accepted no earlier than the cycle after done.
- J and K are never both 1 for the same bit, unless JK_BANK_TOGGLE_EN is defined.

## Configuration
- JK_BANK_TOGGLE_EN defined: every differing bit is driven J=1, K=1 (toggle); equal bits hold. Same final bank value and same latency.
- Not defined: set/reset excitation as in Operation. J&K is always 0.

## Test plan
- W=4, bank at 0000, target=1010 -> J=1010, K=0000 for one cycle; done after 3 edges; err=0; q_fb=1010.
- Bank at 1111, target=0101 -> J=0000, K=1010 (with JK_BANK_TOGGLE_EN: J=K=1010); done after 3 edges; err=0.
- Bench holds q_fb stuck at 0000, target=0001, MAX_RETRY=2 -> three APPLY pulses with J=0001; done with err=1 after 7 edges.
- enabled dropped to 0 during APPLY for 3 cycles -> J=K=0 while low; on re-enable the sequence resumes; done arrives 3 cycles late.
- reset pulsed during SETTLE -> J, K, busy, done and err all 0 immediately; no done pulse; a new start is accepted normally.
- start re-asserted while busy with a different target -> ignored; the first target completes; done occurs once.
